// File: rtl/segre_pkg.sv
// Shared definitions for the segre core.
// The scoreboard uses:
//   - the register-file geometry (REG_SIZE, NUM_REGS),
//   - the write-back bus type (rf_wdata_t),
//   - the scoreboard sizing constants (SB_MAX_INFLIGHT, SB_CNT_W).
package segre_pkg;

  localparam int WORD_SIZE = 32;
  localparam int REG_SIZE  = 5;
  localparam int NUM_REGS  = 32;

  // Scoreboard sizing. 2**SB_CNT_W must exceed SB_MAX_INFLIGHT.
  localparam int SB_MAX_INFLIGHT = 3;
  localparam int SB_CNT_W        = 2;

  // Write-back bus shared with segre_register_file: three independent ports.
  typedef struct packed {
    logic                 ex_we;
    logic [REG_SIZE-1:0]  ex_waddr;
    logic [WORD_SIZE-1:0] ex_data;
    logic                 mem_we;
    logic [REG_SIZE-1:0]  mem_waddr;
    logic [WORD_SIZE-1:0] mem_data;
    logic                 rvm_we;
    logic [REG_SIZE-1:0]  rvm_waddr;
    logic [WORD_SIZE-1:0] rvm_data;
  } rf_wdata_t;

endpackage

// File: rtl/segre_sb_entry.sv
// One scoreboard entry: outstanding-write counter and RVM-owner flag for a
// single architectural register.
// Ports:
//   clk_i, rsn_i  clock, asynchronous active-low reset
//   inc           one new write issued to this register
//   dec           number of write-backs retiring this register (0..3)
//   set_rvm       issued write belongs to the RVM unit
//   clr_rvm       RVM write-back port retired this register
//   cnt           registered outstanding-write count
//   cnt_nxt       count that will be loaded at the next edge
//   rvm           registered RVM-owner flag
//   underflow     more retires than outstanding writes this cycle
module segre_sb_entry
  import segre_pkg::*;
#(
  parameter int CNT_W = SB_CNT_W
) (
  input  logic             clk_i,
  input  logic             rsn_i,
  input  logic             inc,
  input  logic [1:0]       dec,
  input  logic             set_rvm,
  input  logic             clr_rvm,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             rvm,
  output logic             underflow
);

  localparam int SUM_W = CNT_W + 2;

  // Returns {underflow, next count}. Excess retires clamp the count at zero.
  function automatic logic [CNT_W:0] clamp_sub(input logic [CNT_W-1:0] c,
                                                input logic             i,
                                                input logic [1:0]       d);
    logic [SUM_W-1:0] avail;
    avail = SUM_W'(c) + SUM_W'(i);
    if (SUM_W'(d) > avail) begin
      return {1'b1, CNT_W'(0)};
    end
    return {1'b0, CNT_W'(avail - SUM_W'(d))};
  endfunction

  logic [CNT_W:0] upd;

  assign upd       = clamp_sub(cnt, inc, dec);
  assign cnt_nxt   = upd[CNT_W-1:0];
  assign underflow = upd[CNT_W];

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      cnt <= '0;
      rvm <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      // A new RVM issue outranks a same-cycle RVM retire of the older write.
      if (set_rvm) begin
        rvm <= 1'b1;
      end else if (clr_rvm) begin
        rvm <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/segre_rf_scoreboard.sv
// Register-file scoreboard for decode. It counts the outstanding writes per
// architectural register and stalls decode on:
//   - RAW hazards,
//   - WAW hazards involving the RVM unit,
//   - counter saturation.
// Ports:
//   clk_i, rsn_i          clock, asynchronous active-low reset
//   id_*                  decode-stage instruction fields
//   id_ready_o            no hazard; issue = id_valid_i & id_ready_o
//   wdata_i               ex/mem/rvm write-back bus (data fields unused)
//   pending_o             per-register "write outstanding" flags (bit 0 = 0)
//   inflight_o            total outstanding writes, registered
//   err_o                 sticky retire-underflow error
module segre_rf_scoreboard
  import segre_pkg::*;
#(
  parameter int MAX_INFLIGHT = SB_MAX_INFLIGHT,
  parameter int CNT_W        = SB_CNT_W
) (
  input  logic                clk_i,
  input  logic                rsn_i,
  input  logic                id_valid_i,
  input  logic [REG_SIZE-1:0] id_rs1_i,
  input  logic                id_rs1_used_i,
  input  logic [REG_SIZE-1:0] id_rs2_i,
  input  logic                id_rs2_used_i,
  input  logic [REG_SIZE-1:0] id_rd_i,
  input  logic                id_rd_we_i,
  input  logic                id_rvm_i,
  output logic                id_ready_o,
  input  rf_wdata_t           wdata_i,
  output logic [NUM_REGS-1:0] pending_o,
  output logic [6:0]          inflight_o,
  output logic                err_o
);

  logic [CNT_W-1:0]    cnt_q   [NUM_REGS];
  logic [CNT_W-1:0]    cnt_nxt [NUM_REGS];
  logic [NUM_REGS-1:0] rvm_q;
  logic [NUM_REGS-1:0] underflow;
  logic                issue;
  logic                raw1, raw2, waw, sat;
  logic [6:0]          inflight_nxt;
  logic                unused_data;

  // x0 is never tracked: its entry is a constant zero.
  assign cnt_q[0]     = '0;
  assign cnt_nxt[0]   = '0;
  assign rvm_q[0]     = 1'b0;
  assign underflow[0] = 1'b0;

  assign unused_data = ^{wdata_i.ex_data, wdata_i.mem_data, wdata_i.rvm_data};

  // Hazards depend only on registered state and decode fields. There is
  // deliberately no path from wdata_i to id_ready_o.
  assign raw1 = id_rs1_used_i & (id_rs1_i != '0) & (cnt_q[id_rs1_i] != '0);
  assign raw2 = id_rs2_used_i & (id_rs2_i != '0) & (cnt_q[id_rs2_i] != '0);
  assign waw  = id_rd_we_i & (id_rd_i != '0) & (cnt_q[id_rd_i] != '0)
              & (id_rvm_i | rvm_q[id_rd_i]);
  assign sat  = id_rd_we_i & (id_rd_i != '0)
              & (cnt_q[id_rd_i] == CNT_W'(MAX_INFLIGHT));

  assign id_ready_o = ~(raw1 | raw2 | waw | sat);
  assign issue      = id_valid_i & id_ready_o & id_rd_we_i & (id_rd_i != '0);

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
    localparam logic [REG_SIZE-1:0] IDX = REG_SIZE'(i);
    logic       ex_hit, mem_hit, rvm_hit, rd_hit;
    logic [1:0] dec;

    assign ex_hit  = wdata_i.ex_we  & (wdata_i.ex_waddr  == IDX);
    assign mem_hit = wdata_i.mem_we & (wdata_i.mem_waddr == IDX);
    assign rvm_hit = wdata_i.rvm_we & (wdata_i.rvm_waddr == IDX);
    assign rd_hit  = issue & (id_rd_i == IDX);
    assign dec     = 2'(ex_hit) + 2'(mem_hit) + 2'(rvm_hit);

    segre_sb_entry #(
      .CNT_W(CNT_W)
    ) u_entry (
      .clk_i    (clk_i),
      .rsn_i    (rsn_i),
      .inc      (rd_hit),
      .dec      (dec),
      .set_rvm  (rd_hit & id_rvm_i),
      .clr_rvm  (rvm_hit),
      .cnt      (cnt_q[i]),
      .cnt_nxt  (cnt_nxt[i]),
      .rvm      (rvm_q[i]),
      .underflow(underflow[i])
    );
  end

  always_comb begin
    pending_o = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      pending_o[i] = |cnt_q[i];
    end
  end

  // Sum of the next counts, so inflight_o lands in the same edge as the counters.
  always_comb begin
    inflight_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      inflight_nxt = inflight_nxt + 7'(cnt_nxt[i]);
    end
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      inflight_o <= '0;
      err_o      <= 1'b0;
    end else begin
      inflight_o <= inflight_nxt;
      err_o      <= err_o | (|underflow);
    end
  end

endmodule

// File: tb/tb_segre_rf_scoreboard.sv
module tb_segre_rf_scoreboard;
  import segre_pkg::*;

  logic                clk = 1'b0;
  logic                rsn = 1'b0;
  logic                id_valid, id_rs1_used, id_rs2_used, id_rd_we, id_rvm;
  logic [REG_SIZE-1:0] id_rs1, id_rs2, id_rd;
  rf_wdata_t           wdata;
  logic                id_ready, err;
  logic [NUM_REGS-1:0] pending;
  logic [6:0]          inflight;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Behavioural model: plain integer counts per register.
  int m_cnt [NUM_REGS];
  bit m_rvm [NUM_REGS];
  bit m_err;

  always #5 clk = ~clk;

  segre_rf_scoreboard dut (
    .clk_i        (clk),
    .rsn_i        (rsn),
    .id_valid_i   (id_valid),
    .id_rs1_i     (id_rs1),
    .id_rs1_used_i(id_rs1_used),
    .id_rs2_i     (id_rs2),
    .id_rs2_used_i(id_rs2_used),
    .id_rd_i      (id_rd),
    .id_rd_we_i   (id_rd_we),
    .id_rvm_i     (id_rvm),
    .id_ready_o   (id_ready),
    .wdata_i      (wdata),
    .pending_o    (pending),
    .inflight_o   (inflight),
    .err_o        (err)
  );

  function automatic bit m_ready();
    bit h = 1'b0;
    if (id_rs1_used && id_rs1 != 0 && m_cnt[id_rs1] != 0) h = 1'b1;
    if (id_rs2_used && id_rs2 != 0 && m_cnt[id_rs2] != 0) h = 1'b1;
    if (id_rd_we && id_rd != 0 && m_cnt[id_rd] != 0 && (id_rvm || m_rvm[id_rd])) h = 1'b1;
    if (id_rd_we && id_rd != 0 && m_cnt[id_rd] == 3) h = 1'b1;
    return !h;
  endfunction

  function automatic logic [NUM_REGS-1:0] m_pending();
    logic [NUM_REGS-1:0] p = '0;
    for (int i = 1; i < NUM_REGS; i++) p[i] = (m_cnt[i] != 0);
    return p;
  endfunction

  function automatic int m_inflight();
    int s = 0;
    for (int i = 0; i < NUM_REGS; i++) s += m_cnt[i];
    return s;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NUM_REGS; i++) begin
      m_cnt[i] = 0;
      m_rvm[i] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  task automatic model_step();
    int d [NUM_REGS];
    bit iss;
    int v;
    iss = id_valid && m_ready() && id_rd_we && id_rd != 0;
    for (int i = 0; i < NUM_REGS; i++) d[i] = 0;
    if (wdata.ex_we  && wdata.ex_waddr  != 0) d[wdata.ex_waddr]++;
    if (wdata.mem_we && wdata.mem_waddr != 0) d[wdata.mem_waddr]++;
    if (wdata.rvm_we && wdata.rvm_waddr != 0) d[wdata.rvm_waddr]++;
    for (int i = 1; i < NUM_REGS; i++) begin
      v = m_cnt[i] + ((iss && id_rd == i) ? 1 : 0) - d[i];
      if (v < 0) begin
        v = 0;
        m_err = 1'b1;
      end
      m_cnt[i] = v;
    end
    if (wdata.rvm_we && wdata.rvm_waddr != 0) m_rvm[wdata.rvm_waddr] = 1'b0;
    if (iss && id_rvm) m_rvm[id_rd] = 1'b1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready",    64'(id_ready), 64'(m_ready()));
      chk("pending",  64'(pending),  64'(m_pending()));
      chk("inflight", 64'(inflight), 64'(m_inflight()));
      chk("err",      64'(err),      64'(m_err));
    end
  end

  task automatic idle();
    id_valid = 1'b0; id_rs1 = '0; id_rs1_used = 1'b0; id_rs2 = '0; id_rs2_used = 1'b0;
    id_rd = '0; id_rd_we = 1'b0; id_rvm = 1'b0;
    wdata = '0;
  endtask

  task automatic issue(input int rd, input bit rvm);
    id_valid = 1'b1;
    id_rd_we = 1'b1;
    id_rd    = REG_SIZE'(rd);
    id_rvm   = rvm;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rsn) model_step();
    #1;
  endtask

  task automatic retire_all(input int r);
    wdata.ex_we  = 1'b1; wdata.ex_waddr  = REG_SIZE'(r);
    wdata.mem_we = 1'b1; wdata.mem_waddr = REG_SIZE'(r);
    wdata.rvm_we = 1'b1; wdata.rvm_waddr = REG_SIZE'(r);
  endtask

  task automatic rst_mid();
    idle();
    rsn = 1'b0;
    model_clear();
    #1;
    chk("rst_inflight", 64'(inflight), 64'd0);
    chk("rst_pending",  64'(pending),  64'd0);
    chk("rst_err",      64'(err),      64'd0);
    chk("rst_ready",    64'(id_ready), 64'd1);
    @(posedge clk);
    #1;
    rsn = 1'b1;
  endtask

  task automatic drive_random();
    int tmp [NUM_REGS];
    int r;
    for (int i = 0; i < NUM_REGS; i++) tmp[i] = m_cnt[i];
    id_valid    = ($urandom_range(0, 3) != 0);
    id_rs1      = REG_SIZE'($urandom_range(0, 7));
    id_rs1_used = $urandom_range(0, 1) != 0;
    id_rs2      = REG_SIZE'($urandom_range(0, 7));
    id_rs2_used = $urandom_range(0, 1) != 0;
    id_rd       = REG_SIZE'($urandom_range(0, 7));
    id_rd_we    = $urandom_range(0, 3) != 0;
    id_rvm      = ($urandom_range(0, 3) == 0);
    wdata          = '0;
    wdata.ex_data  = $urandom();
    wdata.mem_data = $urandom();
    wdata.rvm_data = $urandom();
    for (int p = 0; p < 3; p++) begin
      if ($urandom_range(0, 1) == 0) begin
        r = $urandom_range(0, 7);
        if (r == 0 || tmp[r] > 0) begin
          if (r != 0) tmp[r]--;
          case (p)
            0: begin wdata.ex_we  = 1'b1; wdata.ex_waddr  = REG_SIZE'(r); end
            1: begin wdata.mem_we = 1'b1; wdata.mem_waddr = REG_SIZE'(r); end
            default: begin wdata.rvm_we = 1'b1; wdata.rvm_waddr = REG_SIZE'(r); end
          endcase
        end
      end
    end
  endtask

  initial begin
    idle();
    model_clear();
    #12;
    chk("reset_ready",    64'(id_ready), 64'd1);
    chk("reset_pending",  64'(pending),  64'd0);
    chk("reset_inflight", 64'(inflight), 64'd0);
    chk("reset_err",      64'(err),      64'd0);
    rsn = 1'b1;
    chk_en = 1'b1;
    tick();

    // RAW on x5, released one cycle after an ex retire
    issue(5, 1'b0); tick(); idle();
    id_valid = 1'b1; id_rs1 = 5'd5; id_rs1_used = 1'b1; #1;
    chk("raw_stall",    64'(id_ready),   64'd0);
    chk("raw_pending5", 64'(pending[5]), 64'd1);
    chk("raw_inflight", 64'(inflight),   64'd1);
    wdata.ex_we = 1'b1; wdata.ex_waddr = 5'd5; #1;
    chk("raw_no_bypass", 64'(id_ready), 64'd0);
    tick(); wdata = '0; #1;
    chk("raw_release",  64'(id_ready),   64'd1);
    chk("raw_clear5",   64'(pending[5]), 64'd0);
    idle();

    // Same-cycle issue and retire on x7
    issue(7, 1'b0); tick(); idle(); #1;
    chk("same_pre_inflight", 64'(inflight), 64'd1);
    issue(7, 1'b0); wdata.mem_we = 1'b1; wdata.mem_waddr = 5'd7;
    tick(); idle(); #1;
    chk("same_pending7", 64'(pending[7]), 64'd1);
    chk("same_inflight", 64'(inflight),   64'd1);
    wdata.ex_we = 1'b1; wdata.ex_waddr = 5'd7; tick(); idle();

    // Triple retire on x9
    issue(9, 1'b0); tick(); tick(); tick(); idle(); #1;
    chk("triple_pre", 64'(inflight), 64'd3);
    retire_all(9); tick(); idle(); #1;
    chk("triple_inflight", 64'(inflight),   64'd0);
    chk("triple_pending9", 64'(pending[9]), 64'd0);

    // Saturation on x3
    issue(3, 1'b0); tick(); tick(); tick(); #1;
    chk("sat_stall", 64'(id_ready), 64'd0);
    tick(); idle(); #1;
    chk("sat_inflight", 64'(inflight), 64'd3);
    retire_all(3); tick(); idle();

    // RVM WAW on x12
    issue(12, 1'b1); tick(); idle();
    issue(12, 1'b0); #1;
    chk("waw_stall", 64'(id_ready), 64'd0);
    tick(); tick(); #1;
    chk("waw_hold", 64'(id_ready), 64'd0);
    wdata.rvm_we = 1'b1; wdata.rvm_waddr = 5'd12; tick(); wdata = '0; #1;
    chk("waw_release", 64'(id_ready), 64'd1);
    idle();

    // x0 issue and retire leave no trace
    issue(0, 1'b1);
    wdata.ex_we = 1'b1; wdata.ex_waddr = 5'd0; wdata.mem_we = 1'b1; wdata.mem_waddr = 5'd0;
    tick(); idle(); #1;
    chk("x0_pending", 64'(pending), 64'd0);
    chk("x0_err",     64'(err),     64'd0);

    // Randomized traffic against the model
    repeat (3000) begin
      drive_random();
      tick();
    end
    repeat (20) begin
      drive_random();
      tick();
    end
    rst_mid();

    // Underflow on x4
    idle();
    wdata.ex_we = 1'b1; wdata.ex_waddr = 5'd4; tick(); idle(); #1;
    chk("uf_err",      64'(err),        64'd1);
    chk("uf_pending4", 64'(pending[4]), 64'd0);
    repeat (5) tick();
    chk("uf_sticky",   64'(err),        64'd1);
    chk("uf_inflight", 64'(inflight),   64'd0);
    rst_mid();
    tick();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/segre_rf_scoreboard.md
# segre_rf_scoreboard

Register-file scoreboard for the decode stage. It tracks, per architectural register, how many issued instructions still owe a write-back. It stalls decode on RAW hazards, on WAW hazards involving the out-of-order RVM unit, and on counter saturation. It observes the same `rf_wdata_t` write-back bus that feeds `segre_register_file`, so a register is released in the same cycle its value is written.

## Interface
Parameters:
- `MAX_INFLIGHT`, default 3: maximum outstanding writes per register.
- `CNT_W`, default 2: per-register counter width. Must satisfy `2**CNT_W > MAX_INFLIGHT`.

Ports:
- `clk_i` in 1: clock.
- `rsn_i` in 1: reset, asynchronous, active-low.
- `id_valid_i` in 1: decode holds an instruction.
- `id_rs1_i` in `REG_SIZE`: source register 1.
- `id_rs1_used_i` in 1: rs1 is read.
- `id_rs2_i` in `REG_SIZE`: source register 2.
- `id_rs2_used_i` in 1: rs2 is read.
- `id_rd_i` in `REG_SIZE`: destination register.
- `id_rd_we_i` in 1: instruction writes rd.
- `id_rvm_i` in 1: instruction executes in the RVM unit.
- `id_ready_o` out 1: no hazard. Issue occurs when `id_valid_i & id_ready_o`.
- `wdata_i` in `rf_wdata_t`: ex/mem/rvm write-back ports (`*_we`, `*_waddr`, `*_data`). Data fields are unused.
- `pending_o` out `NUM_REGS`: bit i set when `cnt[i] != 0`. Bit 0 is always 0.
- `inflight_o` out 7: total outstanding writes across all registers.
- `err_o` out 1: sticky protocol error.

## Operation
- State per register i (1..31): `cnt[i]` (`CNT_W` bits) and `rvm[i]` (1 bit). Register 0 is never tracked. Issues and retires addressing x0 are ignored.
- Hazard evaluation is combinational from registered state and the id inputs only. There is no bypass from the same-cycle write-back.
  - RAW: `id_rs1_used_i & rs1!=0 & cnt[rs1]!=0`, and the same check for rs2.
  - WAW: `id_rd_we_i & rd!=0 & cnt[rd]!=0 & (id_rvm_i | rvm[rd])`.
  - SAT: `id_rd_we_i & rd!=0 & cnt[rd]==MAX_INFLIGHT`.
  - `id_ready_o = !(RAW|WAW|SAT)`. The output is valid even when `id_valid_i=0`.
- Issue (`id_valid_i & id_ready_o & id_rd_we_i & rd!=0`):
  - `inc[rd]=1`.
  - If `id_rvm_i`, `rvm[rd]` is set.
- Retire: for each port p in {ex, mem, rvm} with `p_we & p_waddr!=0`, `dec[p_waddr]` is incremented by 1. Up to 3 decrements can hit the same register in one cycle.
  - An rvm-port retire clears `rvm[waddr]`.
- Next state: `cnt[i] <= cnt[i] + inc[i] - dec[i]`.
  - Issue and retire in the same cycle on the same register are both applied.
  - If `rvm` is set by an issue and cleared by a retire on the same register in the same cycle, set wins.
- Underflow: if `dec[i] > cnt[i] + inc[i]`, then `cnt[i] <= 0` and `err_o` is set. It stays set until reset.
- `inflight_o` is the registered sum of all `cnt[i]`, updated with the counters.

## Timing
- Reset values: all `cnt`=0, all `rvm`=0, `err_o`=0, `inflight_o`=0, `pending_o`=0. With no hazards possible, `id_ready_o`=1.
- Issue at edge t makes the rd hazard visible in cycle t+1.
- Retire at edge t clears the hazard in cycle t+1. This matches the register file's write at edge t, with data readable in t+1.
- `id_ready_o` has zero latency, combinational from id inputs. It must not depend on `wdata_i`, which avoids a comb path from write-back into decode.
- Reset asserted mid-operation clears all state immediately. The pipeline is flushed by the same reset.

## Structure
- Shared package `segre_pkg`:
  - Existing: `REG_SIZE`, `NUM_REGS`, `rf_wdata_t`.
  - New: `SB_MAX_INFLIGHT` and `SB_CNT_W` constants.
- Sub-module `segre_sb_entry`: one register's `cnt`/`rvm` update.
  - Inputs: `inc`, `dec[1:0]`, `set_rvm`, `clr_rvm`.
  - Outputs: `cnt`, `rvm`, `underflow`.
  - Instantiated for registers 1..31 in a generate loop.

## Test plan
- Reset, then RAW: issue `rd=5`. Next cycle, `rs1=5` with `used=1` gives `id_ready_o=0`. After an ex retire of `waddr=5`, `id_ready_o=1` one cycle later, and `pending_o[5]=0`.
- Same-cycle issue and retire: `cnt[7]=1`. Issue `rd=7` while mem retires 7. Then `cnt[7]=1` and `inflight_o` is unchanged.
- Triple retire: `cnt[9]=3`. ex, mem and rvm all retire 9 in one cycle. Then `cnt[9]=0` and `inflight_o` drops by 3.
- Saturation: issue `rd=3` three times (non-rvm) with no retire. The fourth issue to `rd=3` gives `id_ready_o=0`.
- RVM WAW: an rvm op is issued to `rd=12`. A following ex op with `rd=12` stalls until the rvm port retires 12. x0 issue and retire never change `pending_o`.
- Underflow: retire `waddr=4` with `cnt[4]=0`. Then `err_o=1` persists, and `cnt[4]` stays 0 until `rsn_i` is asserted.
